// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Each winner may keep the port for up to MAX_BURST accepted beats.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         ack,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_data,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  = $clog2(MAX_BURST + 1);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] last_grant, last_nxt, grant_nxt;
    logic [IDW-1:0] winner, cand;
    logic [CW-1:0]  beat_cnt, cnt_nxt;
    logic           found, accept;
    logic [WIDTH-1:0] slice [NUM_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            slice[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    // Search upward from the producer after the last owner, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((32'(last_grant) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= LAST_ID;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            grant_id   <= grant_nxt;
            last_grant <= last_nxt;
            beat_cnt   <= cnt_nxt;
        end
    end

    assign grant_valid = (state == BURST);

    always_comb begin
        accept     = 1'b0;
        fifo_wr_en = 1'b0;
        ack        = '0;
        fifo_data  = '0;
        state_nxt  = state;
        grant_nxt  = grant_id;
        last_nxt   = last_grant;
        cnt_nxt    = beat_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = BURST;
                    grant_nxt = winner;
                    last_nxt  = winner;
                    cnt_nxt   = '0;
                end
            end
            BURST: begin
                accept        = req[grant_id] & ~fifo_full;
                fifo_wr_en    = accept;
                ack[grant_id] = accept;
                fifo_data     = slice[grant_id];
                // A dropped request ends the burst; a full FIFO just stalls it.
                if (!req[grant_id]) begin
                    state_nxt = IDLE;
                end else if (accept) begin
                    cnt_nxt = beat_cnt + CW'(1);
                    if (beat_cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle comparison against an
// ownership model plus literal expectations for each scenario.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR-1:0]   req = '0;
    logic [NR*W-1:0] req_data = '0;
    logic [NR-1:0]   ack;
    logic            fifo_full = 1'b0;
    logic            fifo_wr_en;
    logic [W-1:0]    fifo_data;
    logic            grant_valid;
    logic [1:0]      grant_id;

    fifo_wr_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Producers: rem beats still to send, sent beats taken so far.
    int         rem  [NR];
    int         sent [NR];
    logic [31:0] base [NR];
    logic [NR-1:0] ack_seen = '0;
    int cyc = 0;
    int t0;

    // Observation logs filled by the compare process.
    int          wr_id  [$];
    int          wr_cyc [$];
    logic [31:0] wr_dat [$];
    int          gnt    [$];
    int          gv_cnt;
    logic        prev_gv = 1'b0;

    // Model: owner (-1 = nobody), last owner, last reported id, beats taken.
    int m_owner = -1;
    int m_last  = NR - 1;
    int m_gid   = 0;
    int m_beats = 0;
    logic          exp_we;
    logic [NR-1:0] exp_ack;
    logic [W-1:0]  exp_dat;
    logic          m_found;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ack_seen = ack;
        if (rst) begin
            exp_we  = (m_owner >= 0) && req[m_owner] && !fifo_full;
            exp_ack = '0;
            exp_dat = '0;
            if (exp_we) exp_ack[m_owner] = 1'b1;
            if (m_owner >= 0) exp_dat = req_data[m_owner*W +: W];
            check("grant_valid", grant_valid, (m_owner >= 0));
            check("grant_id", grant_id, m_gid);
            check("fifo_wr_en", fifo_wr_en, exp_we);
            check("ack", ack, exp_ack);
            check("fifo_data", fifo_data, exp_dat);
            if (fifo_wr_en) begin
                wr_id.push_back(int'(grant_id));
                wr_cyc.push_back(cyc);
                wr_dat.push_back(fifo_data);
            end
            if (grant_valid && !prev_gv) gnt.push_back(int'(grant_id));
            if (grant_valid) gv_cnt++;
            if (m_owner < 0) begin
                m_found = 1'b0;
                for (int k = 1; k <= NR; k++) begin
                    if (!m_found && req[(m_last + k) % NR]) begin
                        m_found = 1'b1;
                        m_owner = (m_last + k) % NR;
                    end
                end
                if (m_found) begin
                    m_last  = m_owner;
                    m_gid   = m_owner;
                    m_beats = 0;
                end
            end else if (!req[m_owner]) begin
                m_owner = -1;
            end else if (exp_we) begin
                m_beats++;
                if (m_beats == MB) m_owner = -1;
            end
        end else begin
            m_owner = -1;
            m_last  = NR - 1;
            m_gid   = 0;
            m_beats = 0;
        end
        prev_gv = grant_valid;
    end

    task automatic apply();
        for (int i = 0; i < NR; i++) begin
            req[i] = (rem[i] > 0);
            req_data[i*W +: W] = base[i] + 32'(sent[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (ack_seen[i] && rem[i] > 0) begin
                rem[i]--;
                sent[i]++;
            end
        end
        apply();
    endtask

    task automatic clear_logs();
        wr_id.delete();
        wr_cyc.delete();
        wr_dat.delete();
        gnt.delete();
        gv_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rem[i]  = 0;
            sent[i] = 0;
        end
        apply();
        tick();
        tick();
        rst = 1'b1;
        clear_logs();
    endtask

    task automatic wait_sent(input int i, input int n);
        int k;
        k = 0;
        while (sent[i] < n && k < 60) begin
            tick();
            k++;
        end
        check("wait_sent", (sent[i] >= n), 1'b1);
    endtask

    task automatic wait_all_done();
        int k;
        int busy;
        k = 0;
        busy = 1;
        while (busy != 0 && k < 150) begin
            busy = 0;
            for (int i = 0; i < NR; i++) if (rem[i] > 0) busy = 1;
            if (busy != 0) begin
                tick();
                k++;
            end
        end
        check("wait_all_done", (busy == 0), 1'b1);
        repeat (3) tick();
    endtask

    int t1_off [6] = '{1, 2, 3, 4, 6, 7};
    int t2_gnt [5] = '{0, 1, 2, 3, 0};
    int t4_id  [5] = '{1, 1, 3, 3, 3};
    int t4_off [5] = '{1, 2, 5, 6, 7};

    initial begin
        for (int i = 0; i < NR; i++) begin
            rem[i]  = 0;
            sent[i] = 0;
            base[i] = '0;
        end

        // Reset state
        do_reset();
        check("rst_gv", grant_valid, 1'b0);
        check("rst_gid", grant_id, 2'd0);
        check("rst_wr_en", fifo_wr_en, 1'b0);
        check("rst_ack", ack, 4'b0000);

        // 1: single producer, 6 beats
        base[0] = 32'hA0;
        rem[0] = 6;
        apply();
        t0 = cyc;
        wait_sent(0, 6);
        wait_all_done();
        check("t1_nwr", wr_id.size(), 6);
        for (int k = 0; k < 6 && k < wr_id.size(); k++) begin
            check("t1_data", wr_dat[k], 32'hA0 + k);
            check("t1_off", wr_cyc[k] - t0, t1_off[k]);
        end
        check("t1_ngnt", gnt.size(), 2);
        if (gnt.size() == 2) check("t1_gnt1", gnt[1], 0);

        // 2: all producers requesting continuously
        do_reset();
        for (int i = 0; i < NR; i++) base[i] = 32'h100 * (i + 1);
        rem[0] = 8; rem[1] = 4; rem[2] = 4; rem[3] = 4;
        apply();
        wait_all_done();
        check("t2_ngnt", gnt.size(), 5);
        for (int k = 0; k < 5 && k < gnt.size(); k++) check("t2_gnt", gnt[k], t2_gnt[k]);
        check("t2_nwr", wr_id.size(), 20);
        for (int k = 0; k < 20 && k < wr_id.size(); k++) check("t2_wr_id", wr_id[k], t2_gnt[k/4]);

        // 3: back-pressure mid-burst
        do_reset();
        base[2] = 32'hC0;
        rem[2] = 4;
        apply();
        wait_sent(2, 1);
        fifo_full = 1'b1;
        repeat (3) tick();
        fifo_full = 1'b0;
        wait_all_done();
        check("t3_nwr", wr_id.size(), 4);
        if (wr_cyc.size() >= 2) check("t3_stall", wr_cyc[1] - wr_cyc[0], 4);
        check("t3_gv_cycles", gv_cnt, 7);
        check("t3_ngnt", gnt.size(), 1);
        if (gnt.size() >= 1) check("t3_gnt", gnt[0], 2);

        // 4: owner drops request early, next in line takes over
        do_reset();
        base[1] = 32'hB0;
        base[3] = 32'hD0;
        rem[1] = 2;
        rem[3] = 3;
        apply();
        t0 = cyc;
        wait_all_done();
        check("t4_nwr", wr_id.size(), 5);
        for (int k = 0; k < 5 && k < wr_id.size(); k++) begin
            check("t4_wr_id", wr_id[k], t4_id[k]);
            check("t4_off", wr_cyc[k] - t0, t4_off[k]);
        end
        check("t4_ngnt", gnt.size(), 2);

        // 5a: last_grant=1, req=1010 -> 3 wins
        do_reset();
        rem[1] = 1;
        apply();
        wait_sent(1, 1);
        tick();
        clear_logs();
        rem[1] = 1;
        rem[3] = 1;
        apply();
        wait_all_done();
        check("t5a_ngnt", gnt.size(), 2);
        if (gnt.size() == 2) begin
            check("t5a_first", gnt[0], 3);
            check("t5a_second", gnt[1], 1);
        end

        // 5b: last_grant=3 (reset), req=1010 -> 1 wins
        do_reset();
        rem[1] = 1;
        rem[3] = 1;
        apply();
        wait_all_done();
        check("t5b_ngnt", gnt.size(), 2);
        if (gnt.size() == 2) check("t5b_first", gnt[0], 1);

        // 6: reset during owner 3's second beat
        do_reset();
        base[3] = 32'hE0;
        rem[3] = 4;
        apply();
        wait_sent(3, 1);
        rst = 1'b0;
        tick();
        check("t6_gv", grant_valid, 1'b0);
        check("t6_wr_en", fifo_wr_en, 1'b0);
        check("t6_ack", ack, 4'b0000);
        rst = 1'b1;
        clear_logs();
        if (rem[3] == 0) rem[3] = 1;
        rem[0] = 1;
        apply();
        wait_all_done();
        check("t6_ngnt", gnt.size(), 2);
        if (gnt.size() >= 1) check("t6_first", gnt[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares one synchronous FIFO write port among NUM_REQ producers. A winning producer holds the port for a burst of up to MAX_BURST accepted beats. The arbiter honours FIFO back-pressure and returns a per-beat acknowledge to the owner. It sits directly in front of the FIFO write interface (wr_en, data_in, full).

Parameters:
NUM_REQ, 4, number of producers (>=2)
WIDTH, 32, data width; matches FIFO WIDTH
MAX_BURST, 4, maximum accepted beats per grant (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-low reset
req  input  NUM_REQ  per-producer request; high while producer has a beat ready
req_data  input  NUM_REQ*WIDTH  packed producer data; slice i = bits [i*WIDTH +: WIDTH]
ack  output  NUM_REQ  one-hot beat accept; beat of producer i is taken when ack[i]=1
fifo_full  input  1  FIFO full flag
fifo_wr_en  output  1  FIFO write enable
fifo_data  output  WIDTH  FIFO write data
grant_valid  output  1  a burst owner is currently selected
grant_id  output  $clog2(NUM_REQ)  index of the current or last owner

Behaviour:
- Reset is clk-synchronous and active-low: rst=0 sampled at a rising edge forces the reset state on that edge.
- Reset state: FSM=IDLE, grant_valid=0, grant_id=0, beat_cnt=0, last_grant=NUM_REQ-1, so producer 0 has top priority after reset.
- FSM has two states: IDLE and BURST.
- IDLE:
  - fifo_wr_en=0 and ack=0.
  - If any req bit is high, select the first requester found by searching upward from (last_grant+1) mod NUM_REQ with wrap-around.
  - Register grant_id=winner, set last_grant=winner, set grant_valid=1, clear beat_cnt, and go to BURST.
  - Arbitration latency is 1 cycle: the first beat can be accepted in the cycle after the request is seen in IDLE.
- BURST, combinational outputs:
  - fifo_wr_en = req[grant_id] & ~fifo_full.
  - ack[grant_id] = fifo_wr_en; all other ack bits are 0.
  - fifo_data = req_data slice grant_id, driven continuously while grant_valid=1; otherwise 0.
- BURST, on each accepted beat: beat_cnt increments. beat_cnt width is $clog2(MAX_BURST+1).
- BURST exits to IDLE (grant_valid<=0) when either:
  - a beat is accepted with beat_cnt==MAX_BURST-1, or
  - req[grant_id]==0 at the clock edge. No beat is taken in that cycle.
- Every burst is followed by exactly one IDLE cycle, so one bubble per grant is required behaviour.
- Back-pressure: while fifo_full=1, no beat is accepted, beat_cnt holds, and the grant holds indefinitely. There is no timeout.
- Producer rules:
  - req_data must stay stable while req is high and unacked.
  - A producer may deassert req at any time; that ends its burst.
  - A producer may reassert req after losing the port; it then waits its round-robin turn.
- Other producers' req changes during a burst have no effect until the next IDLE.
- grant_id keeps its last value in IDLE. Only grant_valid indicates ownership.
- Reset mid-burst: on the reset edge all state returns to reset values. fifo_wr_en=0 and ack=0 from that cycle on. Partial bursts are dropped without notice.
- At most one FIFO write per cycle. fifo_wr_en is never asserted while fifo_full=1.

Test Plan:
1. Only req[0]=1 for 6 beats, data 0xA0..0xA5, MAX_BURST=4:
   - grant_valid rises 1 cycle after req.
   - ack[0]/fifo_wr_en high for 4 consecutive cycles (0xA0..0xA3), then 1 IDLE cycle.
   - Regrant to 0 follows, then 2 beats (0xA4, 0xA5), then IDLE once req[0] drops.
2. All four req held high continuously, FIFO never full:
   - grant_id sequence 0,1,2,3,0.
   - Each owner gets exactly 4 beats, with one IDLE bubble between grants.
3. Owner 2 mid-burst after 1 beat, fifo_full=1 for 3 cycles:
   - fifo_wr_en=0 and ack=0 for those 3 cycles; grant_id stays 2.
   - After full drops, 3 more beats are accepted, then IDLE.
4. Owner 1 deasserts req after 2 beats while req[3]=1:
   - FSM goes to IDLE on that edge, with no ack that cycle.
   - Next grant_id=3.
5. last_grant=1, req=4'b1010:
   - Winner is 3, not 1.
   - With last_grant=3 and the same req, the winner is 1 (wrap-around).
6. Reset asserted (rst=0) during owner 3's second beat:
   - Next cycle grant_valid=0, fifo_wr_en=0, ack=0.
   - After release with req=4'b1001, first grant goes to 0.
